// File: rtl/updown_pkg.sv
// Shared types for the parametrised up/down counter.
// Direction and wrap/saturate mode enums plus the default width.
package updown_pkg;

   localparam int unsigned DEF_WIDTH = 4;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } mode_e;

endpackage

// File: rtl/param_updown_counter_sticky_flag.sv
// Set-dominant sticky flag register with synchronous clear.
// Ports: clk, rst_n (async low), set_i, clr_i, flag_o.
module sticky_flag (
   input  logic clk,
   input  logic rst_n,
   input  logic set_i,
   input  logic clr_i,
   output logic flag_o
);

   logic flag_q;
   logic flag_d;

   always_comb begin
      flag_d = flag_q;
      if (set_i) begin
         flag_d = 1'b1;
      end else if (clr_i) begin
         flag_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_q <= 1'b0;
      end else begin
         flag_q <= flag_d;
      end
   end

   assign flag_o = flag_q;

endmodule

// File: rtl/param_updown_counter.sv
// Up/down counter modulo MAX_VAL+1: load, wrap/saturate, tc, sticky ovf/unf.
// Ports: clk, reset_n, en, up_down, load, load_val, sat_mode, clr_flags
//        -> count, tc, ovf, unf, at_max, at_min.
module param_updown_counter
   import updown_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned MAX_VAL   = (2**WIDTH) - 1,
   parameter int unsigned RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             up_down,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             sat_mode,
   input  logic             clr_flags,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf,
   output logic             unf,
   output logic             at_max,
   output logic             at_min
);

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] RST_C = WIDTH'(RESET_VAL);
   localparam logic [WIDTH:0]   ONE_X = (WIDTH+1)'(1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             tc_q;
   logic             tc_d;
   logic             ovf_set;
   logic             unf_set;
   logic [WIDTH:0]   inc_x;
   logic [WIDTH:0]   dec_x;
   dir_e             dir;
   mode_e            mode;

   assign dir  = dir_e'(up_down);
   assign mode = mode_e'(sat_mode);

   // Extra bit keeps the carry/borrow out of the visible count;
   // only used when the count is strictly inside the range.
   assign inc_x = {1'b0, count_q} + ONE_X;
   assign dec_x = {1'b0, count_q} - ONE_X;

   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      if (load) begin
         count_d = (load_val > MAX_C) ? MAX_C : load_val;
      end else if (en) begin
         if (dir == DIR_UP) begin
            if (count_q == MAX_C) begin
               ovf_set = 1'b1;
               if (mode == MODE_WRAP) begin
                  count_d = '0;
                  tc_d    = 1'b1;
               end
            end else begin
               count_d = inc_x[WIDTH-1:0];
            end
         end else begin
            if (count_q == '0) begin
               unf_set = 1'b1;
               if (mode == MODE_WRAP) begin
                  count_d = MAX_C;
                  tc_d    = 1'b1;
               end
            end else begin
               count_d = dec_x[WIDTH-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= RST_C;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end

   sticky_flag u_ovf (
      .clk    (clk),
      .rst_n  (reset_n),
      .set_i  (ovf_set),
      .clr_i  (clr_flags),
      .flag_o (ovf)
   );

   sticky_flag u_unf (
      .clk    (clk),
      .rst_n  (reset_n),
      .set_i  (unf_set),
      .clr_i  (clr_flags),
      .flag_o (unf)
   );

   assign count  = count_q;
   assign tc     = tc_q;
   assign at_max = (count_q == MAX_C);
   assign at_min = (count_q == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter (WIDTH=4, MAX_VAL=9).
// Directed literal checks plus randomized run against a behavioural model.
module tb_param_updown_counter;

   localparam int W    = 4;
   localparam int MAXV = 9;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic         en = 1'b0;
   logic         up_down = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic         sat_mode = 1'b0;
   logic         clr_flags = 1'b0;
   logic [W-1:0] count;
   logic         tc;
   logic         ovf;
   logic         unf;
   logic         at_max;
   logic         at_min;

   int n_tot  = 0;
   int n_pass = 0;

   int m_count = 0;
   bit m_tc    = 1'b0;
   bit m_ovf   = 1'b0;
   bit m_unf   = 1'b0;

   param_updown_counter #(
      .WIDTH     (W),
      .MAX_VAL   (MAXV),
      .RESET_VAL (0)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .en        (en),
      .up_down   (up_down),
      .load      (load),
      .load_val  (load_val),
      .sat_mode  (sat_mode),
      .clr_flags (clr_flags),
      .count     (count),
      .tc        (tc),
      .ovf       (ovf),
      .unf       (unf),
      .at_max    (at_max),
      .at_min    (at_min)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: counting rules expressed as plain integer arithmetic.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_count <= 0;
         m_tc    <= 1'b0;
         m_ovf   <= 1'b0;
         m_unf   <= 1'b0;
      end else begin
         m_tc <= 1'b0;
         if (clr_flags) begin
            m_ovf <= 1'b0;
            m_unf <= 1'b0;
         end
         if (load) begin
            m_count <= (int'(load_val) > MAXV) ? MAXV : int'(load_val);
         end else if (en && up_down) begin
            if (m_count == MAXV) begin
               m_ovf   <= 1'b1;
               m_tc    <= !sat_mode;
               m_count <= sat_mode ? MAXV : 0;
            end else begin
               m_count <= m_count + 1;
            end
         end else if (en) begin
            if (m_count == 0) begin
               m_unf   <= 1'b1;
               m_tc    <= !sat_mode;
               m_count <= sat_mode ? 0 : MAXV;
            end else begin
               m_count <= m_count - 1;
            end
         end
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      check("count", int'(count), m_count);
      check("tc", int'(tc), int'(m_tc));
      check("ovf", int'(ovf), int'(m_ovf));
      check("unf", int'(unf), int'(m_unf));
      check("at_max", int'(at_max), int'(m_count == MAXV));
      check("at_min", int'(at_min), int'(m_count == 0));
   end

   task automatic step(input bit ld, input int lv, input bit e,
                       input bit ud, input bit sat, input bit clr);
      load      = ld;
      load_val  = W'(lv);
      en        = e;
      up_down   = ud;
      sat_mode  = sat;
      clr_flags = clr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_count", int'(count), 0);
      check("rst_flags", int'({tc, ovf, unf}), 0);
      reset_n = 1'b1;

      // 1: async reset mid-count
      repeat (5) step(0, 0, 1, 1, 0, 0);
      check("pre_rst", int'(count), 5);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst", int'(count), 0);
      check("async_rst_fl", int'({tc, ovf, unf}), 0);
      @(negedge clk);
      #1 reset_n = 1'b1;
      step(0, 0, 1, 1, 0, 0);
      check("resume1", int'(count), 1);
      step(0, 0, 1, 1, 0, 0);
      check("resume2", int'(count), 2);

      // 2: wrap up from 0
      step(1, 0, 0, 1, 0, 0);
      for (int i = 0; i < 12; i++) begin
         step(0, 0, 1, 1, 0, 0);
         check("up_cnt", int'(count), (i + 1) % 10);
         check("up_tc", int'(tc), int'(i == 9));
      end
      check("up_ovf", int'(ovf), 1);

      // 3: clamped load and saturation
      step(1, 15, 0, 1, 0, 0);
      check("clamp", int'(count), 9);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 1, 1, 0);
         check("sat_cnt", int'(count), 9);
         check("sat_tc", int'(tc), 0);
      end
      check("sat_ovf", int'(ovf), 1);

      // 4: underflow wrap and flag clearing
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      check("dn_wrap", int'(count), 9);
      check("dn_tc", int'(tc), 1);
      check("dn_unf", int'(unf), 1);
      step(1, 3, 0, 0, 0, 0);
      check("dn_tc_drop", int'(tc), 0);
      step(0, 0, 1, 0, 0, 1);
      check("clr_cnt", int'(count), 2);
      check("clr_unf", int'(unf), 0);
      check("clr_ovf", int'(ovf), 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 1);
      check("set_wins", int'(unf), 1);
      check("set_wins_cnt", int'(count), 9);

      // 5: load beats enable
      step(1, 7, 0, 1, 0, 0);
      step(1, 4, 1, 1, 0, 0);
      check("ld_pri", int'(count), 4);
      check("ld_tc", int'(tc), 0);

      // 6: hold with toggling controls
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, i[0], i[1], 0);
         check("hold_cnt", int'(count), 4);
         check("hold_tc", int'(tc), 0);
      end

      // Randomized run
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            #3 reset_n = 1'b0;
            #4 reset_n = 1'b1;
         end
         step($urandom_range(0, 9) == 0,
              int'($urandom_range(0, 15)),
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 15) == 0);
      end

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised successor to the team's 4-bit up/down counter. Counts up or down modulo MAX_VAL+1, with:
- programmable width
- synchronous parallel load
- selectable wrap or saturate mode
- registered terminal-count pulse
- sticky overflow/underflow flags
Used as a general event/timer counter in sequential-circuit exercises and larger datapaths.

Parameters:
WIDTH, 4, counter width in bits (>=2)
MAX_VAL, 2**WIDTH-1, highest count value; count range is 0..MAX_VAL; must be < 2**WIDTH and >= 1
RESET_VAL, 0, value loaded into count on reset; must be <= MAX_VAL

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
en  input  1  count enable
up_down  input  1  1 = count up, 0 = count down
load  input  1  synchronous load strobe
load_val  input  WIDTH  value to load
sat_mode  input  1  1 = saturate at limits, 0 = wrap
clr_flags  input  1  synchronous clear of sticky flags
count  output  WIDTH  current count (registered)
tc  output  1  terminal-count pulse (registered)
ovf  output  1  sticky overflow flag (registered)
unf  output  1  sticky underflow flag (registered)
at_max  output  1  combinational, count == MAX_VAL
at_min  output  1  combinational, count == 0

Behaviour:
- Reset: asynchronous on reset_n low; count=RESET_VAL, tc=0, ovf=0, unf=0; held while reset_n low; release is synchronous to the next clk edge.
- Priority per edge: load > en > hold.
- load=1: count <= min(load_val, MAX_VAL), regardless of en; tc <= 0; flags are not changed by load itself.
- en=1, load=0, up_down=1:
  - count < MAX_VAL: count+1.
  - count == MAX_VAL, sat_mode=0: count <= 0, tc <= 1, ovf <= 1.
  - count == MAX_VAL, sat_mode=1: count stays MAX_VAL, tc <= 0, ovf <= 1.
- en=1, load=0, up_down=0:
  - count > 0: count-1.
  - count == 0, sat_mode=0: count <= MAX_VAL, tc <= 1, unf <= 1.
  - count == 0, sat_mode=1: count stays 0, tc <= 0, unf <= 1.
- tc: high for exactly one cycle following the edge that performed a wrap; otherwise 0. Consecutive wraps (MAX_VAL=1 toggling) may hold tc high on back-to-back cycles.
- en=0, load=0: count holds; tc <= 0.
- clr_flags=1 clears ovf and unf on that edge. If a new overflow/underflow event occurs on the same edge, the set wins for that flag.
- up_down and sat_mode are sampled every edge; changing direction mid-count takes effect on the next enabled edge with no extra latency.
- Arithmetic is performed in WIDTH+1 bits internally; no out-of-range value (>MAX_VAL) ever appears on count.
- at_max/at_min follow count combinationally (0 cycles).
- Latency: count, tc and flags update on the edge where the inputs are sampled; visible one cycle later.

Decomposition:
- Package updown_pkg:
  - typedef enum logic {DIR_DOWN=0, DIR_UP=1} dir_e
  - typedef enum logic {MODE_WRAP=0, MODE_SAT=1} mode_e
  - localparam default WIDTH
- Sub-module sticky_flag (set/clear register, set-dominant, async active-low reset) instantiated twice, for ovf and unf. All other logic stays in the top module.

Test Plan (WIDTH=4, MAX_VAL=9, RESET_VAL=0, 10 ns clock):
1. reset_n=0 mid-count (count=5, en=1) -> count=0, tc=0, ovf=0, unf=0 immediately, without waiting for clk; counting resumes 0,1,2 after release.
2. en=1, up_down=1, sat_mode=0 from 0 for 12 edges -> count 1..9,0,1,2; tc high only the cycle count shows 0 after 9; ovf=1 sticky afterwards.
3. load=1, load_val=15 -> count=9 (clamped). Then en=1, up_down=1, sat_mode=1 for 3 edges -> count stays 9, tc never high, ovf=1.
4. count=0, up_down=0, sat_mode=0, en=1 -> count=9, tc pulse, unf=1. Then clr_flags=1 while count=3 and decrementing -> unf=0 next cycle. clr_flags=1 on the same edge as a 0->9 wrap -> unf remains 1.
5. load=1 and en=1 on the same edge with load_val=4, count=7 -> count=4, tc=0.
6. en=0 with toggling up_down/sat_mode for 5 edges -> count unchanged, tc=0. Check at_max=1 exactly when count=9 and at_min=1 exactly when count=0 throughout all tests.
